// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer arbiter: 640x480 timing
// constants, the holding-buffer state type and the display pipeline depth.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;
    localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;
    localparam int PIPE_LAT = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    // True when a host address points inside the visible frame buffer.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < 32'(depth);
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Host request/response bus of the frame-buffer arbiter.
// master = host side, slave = arbiter side.
interface vga_fb_arbiter_if #(
    parameter int AW = 19,
    parameter int DW = 8
) ();
    logic          HOST_VALID;
    logic          HOST_WE;
    logic [AW-1:0] HOST_ADDR;
    logic [DW-1:0] HOST_WDATA;
    logic          HOST_READY;
    logic [DW-1:0] HOST_RDATA;
    logic          HOST_RVALID;
    logic          HOST_ERR;

    modport master (
        output HOST_VALID, HOST_WE, HOST_ADDR, HOST_WDATA,
        input  HOST_READY, HOST_RDATA, HOST_RVALID, HOST_ERR
    );

    modport slave (
        input  HOST_VALID, HOST_WE, HOST_ADDR, HOST_WDATA,
        output HOST_READY, HOST_RDATA, HOST_RVALID, HOST_ERR
    );
endinterface

// File: rtl/vga_reg.sv
// Generic state register: synchronous active-high reset, load enable.
module vga_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    // Load D when enabled, return to RST_VAL on reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= RST_VAL;
        end else if (EN) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/vga_sync_delay.sv
// N-stage delay line for {PIXEL, H_SYNC, V_SYNC}. Stages reset to the
// idle pattern {0,1,1} so syncs stay deasserted (high) after reset.
module vga_sync_delay #(
    parameter int N = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic pix_in,
    input  logic h_in,
    input  logic v_in,
    output logic pix_out,
    output logic h_out,
    output logic v_out
);

    logic [2:0] stage [1:N];

    // Shift the sync/pixel triple one stage per clock.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 1; i <= N; i++) begin
                stage[i] <= 3'b011;
            end
        end else begin
            stage[1] <= {pix_in, h_in, v_in};
            for (int i = 2; i <= N; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign pix_out = stage[N][2];
    assign h_out   = stage[N][1];
    assign v_out   = stage[N][0];

endmodule

// File: rtl/vga_fb_arbiter.sv
// VGA frame-buffer arbiter. The display refresh owns the single-port RAM on
// every active pixel cycle; host requests wait in a one-entry holding buffer
// and are issued in blanking cycles. Pixel data and syncs leave aligned,
// two cycles after the timing generator inputs.
// Optional build macro VGA_FB_ARB_STARVE_EN adds the STARVE_MAX monitor port.
module vga_fb_arbiter #(
    parameter int DW       = 8,
    parameter int AW       = 19,
    parameter int FB_DEPTH = vga_pkg::FB_DEPTH
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          PIXEL,
    input  logic [AW-1:0] P_COUNT,
    input  logic          H_SYNC,
    input  logic          V_SYNC,
    output logic [AW-1:0] MEM_ADDR,
    output logic          MEM_WE,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    vga_fb_arbiter_if.slave host,
    output logic [DW-1:0] RGB_OUT,
    output logic          H_SYNC_O,
`ifdef VGA_FB_ARB_STARVE_EN
    output logic          V_SYNC_O,
    output logic [9:0]    STARVE_MAX
`else
    output logic          V_SYNC_O
`endif
);
    import vga_pkg::*;

    buf_state_t    state;
    buf_state_t    state_nxt;
    logic [0:0]    state_q;
    logic          slot;
    logic          issue;
    logic          capture;
    logic          in_range;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_wdata;
    logic [AW+DW:0] buf_q;
    logic          rvalid_q;
    logic          err_q;
    logic          rd_ok_q;
    logic [DW-1:0] rdata_q;
    logic          pix_dly;

    vga_reg #(.W(1), .RST_VAL(1'b0)) u_state_reg (
        .CLK (CLK),
        .RST (RST),
        .EN  (1'b1),
        .D   (state_nxt),
        .Q   (state_q)
    );
    assign state = buf_state_t'(state_q);

    vga_reg #(.W(AW+DW+1)) u_buf_reg (
        .CLK (CLK),
        .RST (RST),
        .EN  (capture),
        .D   ({host.HOST_WE, host.HOST_ADDR, host.HOST_WDATA}),
        .Q   (buf_q)
    );
    assign buf_we    = buf_q[AW+DW];
    assign buf_addr  = buf_q[AW+DW-1:DW];
    assign buf_wdata = buf_q[DW-1:0];

    // Any blanking cycle is a free RAM slot; a cycle under reset never issues
    // so a discarded request cannot leak a write.
    assign slot            = ~PIXEL;
    assign issue           = (state == FULL) && slot && !RST;
    assign host.HOST_READY = (state == EMPTY) || slot;
    assign capture         = host.HOST_VALID && host.HOST_READY;
    assign in_range        = addr_in_range(32'(buf_addr), FB_DEPTH);

    // Holding-buffer next state: refill in the same slot it drains.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (capture) begin
                    state_nxt = FULL;
                end else begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (issue && !capture) begin
                    state_nxt = EMPTY;
                end else begin
                    state_nxt = FULL;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // RAM port mux: display first, in-range host issue second, idle otherwise.
    always_comb begin
        MEM_ADDR  = {AW{1'b0}};
        MEM_WE    = 1'b0;
        MEM_WDATA = {DW{1'b0}};
        if (PIXEL) begin
            MEM_ADDR = P_COUNT;
        end else if (issue && in_range) begin
            MEM_ADDR  = buf_addr;
            MEM_WE    = buf_we;
            MEM_WDATA = buf_wdata;
        end else begin
            MEM_ADDR = {AW{1'b0}};
        end
    end

    // Host response pulses, one cycle after the issue cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rd_ok_q  <= 1'b0;
        end else begin
            rvalid_q <= issue && !buf_we;
            err_q    <= issue && !in_range;
            rd_ok_q  <= issue && !buf_we && in_range;
        end
    end

    assign host.HOST_RVALID = rvalid_q;
    assign host.HOST_ERR    = err_q;
    assign host.HOST_RDATA  = rd_ok_q ? MEM_RDATA : {DW{1'b0}};

    vga_sync_delay #(.N(PIPE_LAT)) u_sync_delay (
        .CLK     (CLK),
        .RST     (RST),
        .pix_in  (PIXEL),
        .h_in    (H_SYNC),
        .v_in    (V_SYNC),
        .pix_out (pix_dly),
        .h_out   (H_SYNC_O),
        .v_out   (V_SYNC_O)
    );

    // Register RAM read data so pixel data lines up with the delayed syncs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_q <= {DW{1'b0}};
        end else begin
            rdata_q <= MEM_RDATA;
        end
    end

    assign RGB_OUT = pix_dly ? rdata_q : {DW{1'b0}};

`ifdef VGA_FB_ARB_STARVE_EN
    logic [9:0] wait_cnt;
    logic [9:0] wait_nxt;
    logic [9:0] max_q;
    logic       v_prev;

    // Wait counter: grows while a request is stuck behind active video.
    always_comb begin
        wait_nxt = wait_cnt;
        if (issue) begin
            wait_nxt = 10'd0;
        end else if ((state == FULL) && !slot && (wait_cnt != 10'h3FF)) begin
            wait_nxt = wait_cnt + 10'd1;
        end else begin
            wait_nxt = wait_cnt;
        end
    end

    // Track the worst wait seen, restarting at each new frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt <= 10'd0;
            max_q    <= 10'd0;
            v_prev   <= 1'b1;
        end else begin
            wait_cnt <= wait_nxt;
            v_prev   <= V_SYNC_O;
            if (V_SYNC_O && !v_prev) begin
                max_q <= 10'd0;
            end else if (wait_nxt > max_q) begin
                max_q <= wait_nxt;
            end else begin
                max_q <= max_q;
            end
        end
    end

    assign STARVE_MAX = max_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: a stimulus process drives the
// timing/host inputs and a frame-buffer reference model pushes expected
// responses; a negedge monitor pops and compares them.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    localparam int AW = 19;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          PIXEL;
    logic [AW-1:0] P_COUNT;
    logic          H_SYNC;
    logic          V_SYNC;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_WE;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA;
    logic [DW-1:0] RGB_OUT;
    logic          H_SYNC_O;
    logic          V_SYNC_O;
`ifdef VGA_FB_ARB_STARVE_EN
    logic [9:0]    STARVE_MAX;
`endif

    vga_fb_arbiter_if #(.AW(AW), .DW(DW)) hif ();

    vga_fb_arbiter #(.DW(DW), .AW(AW), .FB_DEPTH(FB_DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PIXEL     (PIXEL),
        .P_COUNT   (P_COUNT),
        .H_SYNC    (H_SYNC),
        .V_SYNC    (V_SYNC),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WE    (MEM_WE),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RDATA (MEM_RDATA),
        .host      (hif),
        .RGB_OUT   (RGB_OUT),
        .H_SYNC_O  (H_SYNC_O),
`ifdef VGA_FB_ARB_STARVE_EN
        .V_SYNC_O  (V_SYNC_O),
        .STARVE_MAX(STARVE_MAX)
`else
        .V_SYNC_O  (V_SYNC_O)
`endif
    );

    always #5 CLK = ~CLK;

    // Single-port RAM, one-cycle read latency.
    logic [DW-1:0] ram [0:FB_DEPTH-1];
    always @(posedge CLK) begin
        if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
        MEM_RDATA <= ram[MEM_ADDR];
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:FB_DEPTH-1];
    typedef struct { int due; logic [DW-1:0] rgb; logic h; logic v; } disp_t;
    typedef struct { int due; logic rvalid; logic err; logic [DW-1:0] data; } resp_t;
    disp_t dq[$];
    resp_t rq[$];
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;
    bit    pend = 1'b0;
    bit    p_we;
    int    p_addr;
    logic [DW-1:0] p_data;
    int    starve_run = 0;
    int    starve_best = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle of stimulus plus the reference model's view of it.
    task automatic step(input logic rst, input logic pix, input int pc, input logic h, input logic v,
                        input logic hv, input logic hwe, input int haddr, input logic [DW-1:0] hwd,
                        output bit cap);
        bit exp_ready;
        bit exp_we;
        @(posedge CLK);
        cyc++;
        #1;
        RST            = rst;
        PIXEL          = pix;
        P_COUNT        = pc[AW-1:0];
        H_SYNC         = h;
        V_SYNC         = v;
        hif.HOST_VALID = hv;
        hif.HOST_WE    = hwe;
        hif.HOST_ADDR  = haddr[AW-1:0];
        hif.HOST_WDATA = hwd;
        #1;
        cap = 1'b0;
        if (rst) begin
            check("mem_we_in_reset", MEM_WE, 0);
            pend = 1'b0;
            starve_run = 0;
            while (rq.size() > 0 && rq[$].due > cyc) void'(rq.pop_back());
            while (dq.size() > 0 && dq[$].due > cyc) void'(dq.pop_back());
            dq.push_back('{cyc + 1, 8'h00, 1'b1, 1'b1});
            dq.push_back('{cyc + 2, 8'h00, 1'b1, 1'b1});
        end else begin
            exp_ready = !pend || !pix;
            check("host_ready", hif.HOST_READY, exp_ready);
            exp_we = 1'b0;
            if (pend && !pix) begin
                if (p_addr >= FB_DEPTH) begin
                    rq.push_back('{cyc + 1, !p_we, 1'b1, 8'h00});
                end else if (p_we) begin
                    exp_we = 1'b1;
                    ref_mem[p_addr] = p_data;
                    check("mem_waddr", MEM_ADDR, p_addr);
                    check("mem_wdata", MEM_WDATA, p_data);
                end else begin
                    rq.push_back('{cyc + 1, 1'b1, 1'b0, ref_mem[p_addr]});
                end
                pend = 1'b0;
                starve_run = 0;
            end else if (pend && pix) begin
                starve_run++;
                if (starve_run > starve_best) starve_best = starve_run;
            end
            check("mem_we", MEM_WE, exp_we);
            if (pix) check("mem_addr_disp", MEM_ADDR, pc);
            if (hv && exp_ready) begin
                cap    = 1'b1;
                pend   = 1'b1;
                p_we   = hwe;
                p_addr = haddr;
                p_data = hwd;
            end
            dq.push_back('{cyc + 2, pix ? ref_mem[pc] : 8'h00, h, v});
        end
    endtask

    // Hold a host request until the arbiter accepts it (bounded).
    task automatic host_req(input logic pix, input logic we, input int addr, input logic [DW-1:0] d);
        bit cap = 1'b0;
        for (int k = 0; k < 2000 && !cap; k++) begin
            step(1'b0, pix, 5, 1'b1, 1'b1, 1'b1, we, addr, d, cap);
        end
        if (!cap) check("host_accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n, input logic v);
        bit cap;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 1'b1, v, 1'b0, 1'b0, 0, 8'h00, cap);
    endtask

    // Monitor: pop scoreboard entries as the DUT presents outputs.
    always @(negedge CLK) begin
        disp_t d;
        resp_t r;
        if (dq.size() > 0 && dq[0].due == cyc) begin
            d = dq.pop_front();
            check("rgb_out", RGB_OUT, d.rgb);
            check("h_sync_o", H_SYNC_O, d.h);
            check("v_sync_o", V_SYNC_O, d.v);
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            check("host_rvalid", hif.HOST_RVALID, r.rvalid);
            check("host_err", hif.HOST_ERR, r.err);
            if (r.rvalid) check("host_rdata", hif.HOST_RDATA, r.data);
        end else if (cyc > 0) begin
            check("no_spurious_resp", {hif.HOST_RVALID, hif.HOST_ERR}, 0);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit cap;
        bit done;
        int run_left;
        bit cur_pix;
        int a;
        for (int i = 0; i < FB_DEPTH; i++) begin
            ram[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        for (int i = 0; i < 4; i++) begin
            ram[i]     = 8'hA0 + 8'(i);
            ref_mem[i] = 8'hA0 + 8'(i);
        end
        RST = 1'b1; PIXEL = 1'b0; P_COUNT = '0; H_SYNC = 1'b1; V_SYNC = 1'b1;
        hif.HOST_VALID = 1'b0; hif.HOST_WE = 1'b0; hif.HOST_ADDR = '0; hif.HOST_WDATA = '0;

        // Reset, then display pixels 0..3 with varying syncs.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h00, cap);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i, i[0], i[1], 1'b0, 1'b0, 0, 8'h00, cap);
        idle(3, 1'b0);
        idle(2, 1'b1);

        // Write posted during active video, issued in the first blank cycle.
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, i + 10, 1'b1, 1'b1, !done, 1'b1, 100, 8'h5C, cap);
            if (cap) done = 1'b1;
        end
        if (!done) check("write_capture", 0, 1);
        idle(3, 1'b1);
        host_req(1'b0, 1'b0, 100, 8'h00);
        idle(3, 1'b1);

        // Back-to-back reads in blanking.
        host_req(1'b0, 1'b0, 7, 8'h00);
        host_req(1'b0, 1'b0, 8, 8'h00);
        host_req(1'b0, 1'b0, 9, 8'h00);
        idle(3, 1'b1);

        // Out-of-range read and write.
        host_req(1'b0, 1'b0, FB_DEPTH, 8'h00);
        idle(2, 1'b1);
        host_req(1'b0, 1'b1, FB_DEPTH + 5, 8'h33);
        idle(3, 1'b1);

        // Captured write discarded by reset before its slot.
        host_req(1'b1, 1'b1, 200, 8'hEE);
        step(1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h00, cap);
        idle(3, 1'b1);
        host_req(1'b0, 1'b0, 200, 8'h00);
        idle(3, 1'b1);

        // Randomised traffic with mixed active/blank runs.
        run_left = 0;
        cur_pix  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                cur_pix  = !cur_pix;
                run_left = $urandom_range(1, 12);
            end
            run_left--;
            if ($urandom_range(0, 7) == 0) a = $urandom_range(FB_DEPTH, (1 << AW) - 1);
            else a = $urandom_range(0, 63);
            step(($urandom_range(0, 299) == 0), cur_pix, $urandom_range(0, FB_DEPTH - 1),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), a, 8'($urandom), cap);
        end
        idle(4, 1'b1);

`ifdef VGA_FB_ARB_STARVE_EN
        // Clear the monitor with a vsync rise, then starve a request for a full line.
        idle(2, 1'b0);
        idle(5, 1'b1);
        starve_run  = 0;
        starve_best = 0;
        host_req(1'b1, 1'b1, 300, 8'h77);
        for (int i = 1; i < H_ACTIVE; i++) step(1'b0, 1'b1, i, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h00, cap);
        idle(4, 1'b1);
        check("starve_max", STARVE_MAX, starve_best);
        idle(2, 1'b0);
        idle(5, 1'b1);
        check("starve_max_clear", STARVE_MAX, 0);
`endif

        idle(4, 1'b1);
        check("resp_queue_drained", rq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer RAM between the VGA640x480 display refresh stream (absolute priority) and a host read/write port.
- Display reads are issued on every active pixel cycle.
- Host accesses are posted into a one-entry holding buffer and issued only in blanking cycles.
- Produces pixel data and delays the syncs so both are cycle-aligned for the DAC.

Parameters:
- DW, 8, pixel/data width (RGB332).
- AW, 19, address width, matching the timing generator's P_COUNT.
- FB_DEPTH, 307200, number of valid frame-buffer words (640x480).

Ports:
- CLK in 1: clock.
- RST in 1: synchronous, active-high reset.
- PIXEL in 1: active-video flag from the timing generator.
- P_COUNT in AW: pixel address from the timing generator.
- H_SYNC in 1: raw horizontal sync.
- V_SYNC in 1: raw vertical sync.
- MEM_ADDR out AW: RAM address.
- MEM_WE out 1: RAM write enable.
- MEM_WDATA out DW: RAM write data.
- MEM_RDATA in DW: RAM read data, valid 1 cycle after the address.
- HOST_VALID in 1: host request valid.
- HOST_WE in 1: 1 = write, 0 = read.
- HOST_ADDR in AW: host address.
- HOST_WDATA in DW: host write data.
- HOST_READY out 1: holding buffer can accept a request.
- HOST_RDATA out DW: read data.
- HOST_RVALID out 1: 1-cycle pulse, HOST_RDATA valid.
- HOST_ERR out 1: 1-cycle pulse, out-of-range host address.
- RGB_OUT out DW: pixel data to the DAC.
- H_SYNC_O out 1: horizontal sync aligned to RGB_OUT.
- V_SYNC_O out 1: vertical sync aligned to RGB_OUT.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: state EMPTY, HOST_READY=1, HOST_RVALID=0, HOST_ERR=0, RGB_OUT=0, H_SYNC_O=1, V_SYNC_O=1, sync/pixel pipeline cleared.
- State machine (holding buffer):
  - EMPTY: HOST_VALID&&HOST_READY captures {WE,ADDR,WDATA} and moves to FULL.
  - FULL: waits for a slot. A slot is a cycle with PIXEL=0.
  - In a slot, the buffer issues: FULL -> EMPTY, or stays FULL if a new request is captured in the same cycle.
- HOST_READY = (state==EMPTY) || slot. This is a combinational path from PIXEL.
- Address range: if the captured ADDR >= FB_DEPTH, the issue cycle drives no RAM access (MEM_WE=0). Instead:
  - HOST_ERR pulses the next cycle.
  - A read also pulses HOST_RVALID with HOST_RDATA=0.
- Memory port mux (combinational):
  - PIXEL=1: MEM_ADDR=P_COUNT, MEM_WE=0.
  - Host issue cycle: MEM_ADDR=buffer addr, MEM_WE=buffer WE, MEM_WDATA=buffer data.
  - Otherwise: MEM_ADDR=0, MEM_WE=0.
  - The display is never stalled or skipped.
- Host read latency:
  - Read issued at cycle t: HOST_RVALID=1 at t+1 with HOST_RDATA=MEM_RDATA, registered from the t+1 capture.
  - Back-to-back reads are fully pipelined.
- Host write: completes in the issue cycle. There is no response pulse.
- Display pipeline:
  - PIXEL at t appears as RGB_OUT at t+2 (MEM_RDATA registered).
  - RGB_OUT=0 when the delayed PIXEL is 0.
  - H_SYNC/V_SYNC are delayed by the same 2 flops.
- Worst-case host wait is one active line (640 cycles). Blanking gives 160 slots per line and 45 full lines per frame.
- Reset mid-operation:
  - A pending buffered request is discarded.
  - An in-flight read produces no RVALID.

Optional Feature:
- Macro: VGA_FB_ARB_STARVE_EN.
- When defined:
  - Adds output STARVE_MAX[9:0], reset 0.
  - A wait counter counts cycles in FULL without a slot. It clears on issue and saturates at 1023.
  - STARVE_MAX holds the largest count seen. It clears on RST or on the rising edge of V_SYNC_O.
- When undefined: no port and no counter logic.

Decomposition:
- Shared package vga_pkg holds:
  - Timing constants H_ACTIVE=640, H_TOTAL=800, V_ACTIVE=480, V_TOTAL=525, FB_DEPTH.
  - Holding-buffer state typedef {EMPTY, FULL}.
  - Display pipeline depth constant PIPE_LAT=2.
- One natural sub-module, vga_sync_delay: a parameterised N-stage delay line for {PIXEL,H_SYNC,V_SYNC}. Its flops reset to {0,1,1}.
- State registers use the existing REG block (parameterised width, with EN).

Test Plan:
- Reset, then PIXEL=1 with P_COUNT=0..3 and the RAM model preloaded with 8'hA0..A3 -> RGB_OUT=A0,A1,A2,A3 starting 2 cycles later; syncs delayed by 2.
- Host write ADDR=100, WDATA=8'h5C during PIXEL=1 for 10 cycles -> HOST_READY=0 after capture, MEM_WE=0 throughout, write issued on the first PIXEL=0 cycle; a read of 100 then returns 5C with RVALID 1 cycle after issue.
- Back-to-back host reads of addresses 7,8,9 during blanking -> three RVALID pulses on consecutive cycles with the correct data; HOST_READY stays 1.
- Host read ADDR=307200 -> no RAM access, HOST_ERR and HOST_RVALID pulse together, HOST_RDATA=0.
- Request captured, then RST asserted for 1 cycle before a slot -> no RAM write occurs and state is EMPTY with HOST_READY=1.
- With VGA_FB_ARB_STARVE_EN: request held across a 640-cycle active run -> STARVE_MAX=640 (±1 per capture timing); STARVE_MAX clears to 0 at the next V_SYNC_O rise.
